uart_tx: RTL
============

Name: uart_tx

Overview:
UART transmitter: the transmit-side counterpart of the UART RX path. It accepts one parallel byte per frame through a valid strobe and serialises it onto a single line, LSB first. Frame: start bit, 8 data bits, optional parity bit, stop bit. Bit timing comes from a per-bit clock-count prescale, matching the oversampling prescale used by the receiver so both ends share one system clock configuration.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_WIDTH, 6, width of the Prescale input

Ports:
Clk  input  1  system clock; all logic on rising edge
Rst  input  1  synchronous active-low reset, sampled on rising Clk
P_DATA  input  DATA_WIDTH  byte to transmit, sampled on accept
Data_Valid  input  1  request strobe; accepted only when the block is idle
PAR_EN  input  1  1 = parity bit inserted; sampled on accept
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on accept
Prescale  input  PRESCALE_WIDTH  clock cycles per bit; sampled on accept; 0 treated as 1
TX_OUT  output  1  serial line; idles high
Busy  output  1  high from the first start-bit cycle through the last stop-bit cycle

Behaviour:
- Reset is synchronous and active-low: Rst=0 at a rising Clk edge puts the block in IDLE with TX_OUT=1, Busy=0, and clears the bit counter, the prescale counter and the data/config latches. Reset mid-frame abandons the frame, and the line returns high on that same edge.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered: TX_OUT and Busy change only on Clk edges.
- IDLE: TX_OUT=1, Busy=0. If Data_Valid=1 on edge N, then P_DATA, PAR_EN, PAR_TYP and Prescale are latched. The latched Prescale is forced to 1 if it is 0. The FSM moves to START.
- Accept latency: from edge N+1, TX_OUT=0 and Busy=1.
- Each bit state holds for exactly P latched-prescale cycles. The prescale counter runs 0..P-1 and advances the state at P-1.
- START: drives 0 for P cycles, then goes to DATA.
- DATA: drives latched bit k for k=0..DATA_WIDTH-1, LSB first, P cycles each. The bit counter wraps after bit DATA_WIDTH-1. The next state is PARITY if the latched PAR_EN=1, otherwise STOP.
- PARITY: drives the XOR-reduction of the latched data when PAR_TYP=0 (even), or its inverse when PAR_TYP=1 (odd). Lasts P cycles, then goes to STOP.
- STOP: drives 1 for P cycles, then goes to IDLE. Busy falls on the edge entering IDLE.
- Frame length: F = (DATA_WIDTH+2+PAR_EN)*P cycles. Busy is high for exactly F cycles.
- Data_Valid while not in IDLE is ignored; no queuing. Input changes after accept have no effect on the frame in flight.
- Back-to-back frames: Data_Valid held high gives a new accept on the first IDLE edge. The stop bit is therefore followed by exactly 1 idle-high cycle before the next start bit.
- Simultaneous Rst=0 and Data_Valid=1: reset wins and nothing is accepted.
- Prescale counter and bit counter are sized to hold PRESCALE_WIDTH bits and log2(DATA_WIDTH) bits respectively. No counter overflows at the maximum Prescale of 2^PRESCALE_WIDTH-1.

Test Plan:
1. Rst=0 for 3 cycles, then release -> TX_OUT=1 and Busy=0 from the first reset edge; stays idle with Data_Valid=0.
2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Prescale=8, 1-cycle Data_Valid -> line sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 8 cycles; Busy high for exactly 88 cycles.
3. Same byte with PAR_TYP=1 -> parity bit=1. With PAR_EN=0 -> 10 bits and Busy high for exactly 80 cycles.
4. Data_Valid pulsed with P_DATA=0x3C in the middle of frame 2, and P_DATA changed after accept -> ignored; the transmitted frame is unchanged and no second frame follows.
5. Data_Valid held high, P_DATA=0xFF, then 0x00, Prescale=1 -> frames of 11 cycles separated by exactly 1 idle-high cycle. Parity bits (even) are 0 for 0xFF and 0 for 0x00.
6. Rst=0 asserted during DATA bit 4 -> next edge gives TX_OUT=1, Busy=0. A new Data_Valid after release starts a clean frame with a full-length start bit. Prescale=0 yields 1-cycle bits.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, stop
// Every output is registered, so TX_OUT and Busy change only on rising Clk.
module uart_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]                r_state;
  logic [DATA_WIDTH-1:0]     r_data;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] r_pcnt;
  logic [BW-1:0]             r_bitcnt;
  logic                      r_tx;
  logic                      r_busy;

  logic                      w_bit_end;
  logic                      w_parity;
  logic [BW-1:0]             w_next_bit;

  // r_prescale is never 0, so P-1 cannot underflow
  assign w_bit_end  = (r_pcnt == (r_prescale - 1'b1));
  assign w_parity   = (^r_data) ^ r_par_typ;
  assign w_next_bit = r_bitcnt + 1'b1;

  assign TX_OUT = r_tx;
  assign Busy   = r_busy;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_prescale <= '0;
      r_pcnt     <= '0;
      r_bitcnt   <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx     <= 1'b1;
          r_busy   <= 1'b0;
          r_pcnt   <= '0;
          r_bitcnt <= '0;
          if (Data_Valid) begin
            r_data     <= P_DATA;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_prescale <= (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
            r_state    <= START;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        START: begin
          if (w_bit_end) begin
            r_pcnt   <= '0;
            r_bitcnt <= '0;
            r_tx     <= r_data[0];
            r_state  <= DATA;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end

        DATA: begin
          if (w_bit_end) begin
            r_pcnt <= '0;
            if (r_bitcnt == LAST_BIT) begin
              r_bitcnt <= '0;
              if (r_par_en) begin
                r_tx    <= w_parity;
                r_state <= PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= STOP;
              end
            end else begin
              r_bitcnt <= w_next_bit;
              r_tx     <= r_data[w_next_bit];
            end
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end

        PARITY: begin
          if (w_bit_end) begin
            r_pcnt  <= '0;
            r_tx    <= 1'b1;
            r_state <= STOP;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end

        STOP: begin
          if (w_bit_end) begin
            r_pcnt  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_pcnt  <= '0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
